// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with valid/ready handshake and a
// 2-entry skid buffer (main reg M drives the outputs, skid reg S absorbs one word
// of backpressure). ready_out/valid_out decode from registered state only.
// Optional starvation counter: define PIPE_STAGE_BUBBLE_CNT_EN to add bubble_cnt.
module pipe_stage_buf #(
   parameter int unsigned               DATA_WIDTH  = 32,
   parameter int unsigned               CTRL_WIDTH  = 16,
   parameter logic [CTRL_WIDTH-1:0]     CTRL_BUBBLE = '0,
   parameter int unsigned               CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CTRL_WIDTH-1:0] ctrl_in,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CTRL_WIDTH-1:0] ctrl_out,
   output logic [1:0]            occupancy
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] m_data;
   logic [CTRL_WIDTH-1:0] m_ctrl;
   logic [DATA_WIDTH-1:0] s_data;
   logic [CTRL_WIDTH-1:0] s_ctrl;
   logic                  push;
   logic                  pop;
   logic                  load_m_in;
   logic                  load_m_s;
   logic                  load_s_in;

   assign push = valid_in & ready_out;
   assign pop  = valid_out & ready_in;

   // Output decode from registered state; bubbles always carry safe controls.
   always_comb begin
      valid_out = (state_q != EMPTY);
      ready_out = (state_q != FULL);
      occupancy = 2'd0;
      case (state_q)
         HALF:    occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
      data_out = m_data;
      ctrl_out = valid_out ? m_ctrl : CTRL_BUBBLE;
   end

   // Next-state and register-load selection; flush overrides push/pop.
   always_comb begin
      state_d   = state_q;
      load_m_in = 1'b0;
      load_m_s  = 1'b0;
      load_s_in = 1'b0;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d   = HALF;
               load_m_in = 1'b1;
            end
         end
         HALF: begin
            if (push && pop) begin
               load_m_in = 1'b1;
            end else if (push) begin
               state_d   = FULL;
               load_s_in = 1'b1;
            end else if (pop) begin
               state_d   = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d  = HALF;
               load_m_s = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // A word pushed during flush is dropped; M keeps its last value.
      if (flush) begin
         state_d   = EMPTY;
         load_m_in = 1'b0;
         load_m_s  = 1'b0;
         load_s_in = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Main and skid payload registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data <= '0;
         m_ctrl <= CTRL_BUBBLE;
         s_data <= '0;
         s_ctrl <= CTRL_BUBBLE;
      end else begin
         if (load_m_in) begin
            m_data <= data_in;
            m_ctrl <= ctrl_in;
         end else if (load_m_s) begin
            m_data <= s_data;
            m_ctrl <= s_ctrl;
         end
         if (load_s_in) begin
            s_data <= data_in;
            s_ctrl <= ctrl_in;
         end
      end
   end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
   // Saturating count of cycles where downstream was ready but we had nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (ready_in && !valid_out && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`else
   logic unused_cnt_width;
   assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table, hand-written
// corner sequences (throughput, async reset, bubble counter) and random traffic
// compared against a queue-based reference model.
module tb_pipe_stage_buf;

   localparam logic [3:0] BUB = 4'hA;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       valid_in = 1'b0;
   logic       ready_out;
   logic [7:0] data_in = '0;
   logic [3:0] ctrl_in = '0;
   logic       valid_out;
   logic       ready_in = 1'b0;
   logic [7:0] data_out;
   logic [3:0] ctrl_out;
   logic [1:0] occupancy;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
   logic [1:0] bubble_cnt;
`endif

   int total = 0;
   int bad = 0;

   // reference model: FIFO of {ctrl,data} plus saturating starvation count
   logic [11:0] q[$];
   int          bub = 0;

   pipe_stage_buf #(
      .DATA_WIDTH (8),
      .CTRL_WIDTH (4),
      .CTRL_BUBBLE(BUB),
      .CNT_WIDTH  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_in   (data_in),
      .ctrl_in   (ctrl_in),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .ctrl_out  (ctrl_out),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      ,
      .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vin;
      logic [7:0] d;
      logic [3:0] c;
      logic       rdy;
      logic       fl;
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
      logic [1:0] eo;
      logic       er;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, land at edge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic [3:0] c,
                       input logic r, input logic f);
      bit m_pop, m_push;
      valid_in = v;
      data_in  = d;
      ctrl_in  = c;
      ready_in = r;
      flush    = f;
      m_pop  = (q.size() > 0) && r;
      m_push = v && (q.size() < 2);
      if (r && q.size() == 0 && bub < 3) bub++;
      @(posedge clk);
      #1;
      if (f) begin
         q.delete();
      end else begin
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back({c, d});
      end
   endtask

   task automatic model_check(input string tag);
      chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, q.size() != 0});
      chk({tag, ".ready"}, {31'd0, ready_out}, {31'd0, q.size() != 2});
      chk({tag, ".occ"}, {30'd0, occupancy}, q.size());
      if (q.size() != 0) begin
         chk({tag, ".data"}, {24'd0, data_out}, {24'd0, q[0][7:0]});
         chk({tag, ".ctrl"}, {28'd0, ctrl_out}, {28'd0, q[0][11:8]});
      end else begin
         chk({tag, ".ctrl_bub"}, {28'd0, ctrl_out}, {28'd0, BUB});
      end
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      chk({tag, ".bubble"}, {30'd0, bubble_cnt}, bub);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b0;
      flush = 1'b0;
      q.delete();
      bub = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, 8'hA5, 4'h3, 1'b1, 1'b0, 1'b1, 8'hA5, 4'h3, 2'd1, 1'b1};
      tbl[1]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, BUB,  2'd0, 1'b1};
      tbl[2]  = '{1'b1, 8'h01, 4'h1, 1'b0, 1'b0, 1'b1, 8'h01, 4'h1, 2'd1, 1'b1};
      tbl[3]  = '{1'b1, 8'h02, 4'h2, 1'b0, 1'b0, 1'b1, 8'h01, 4'h1, 2'd2, 1'b0};
      tbl[4]  = '{1'b1, 8'h03, 4'h3, 1'b0, 1'b0, 1'b1, 8'h01, 4'h1, 2'd2, 1'b0};
      tbl[5]  = '{1'b1, 8'h03, 4'h3, 1'b1, 1'b0, 1'b1, 8'h02, 4'h2, 2'd1, 1'b1};
      tbl[6]  = '{1'b1, 8'h03, 4'h3, 1'b1, 1'b0, 1'b1, 8'h03, 4'h3, 2'd1, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, BUB,  2'd0, 1'b1};
      tbl[8]  = '{1'b1, 8'h07, 4'h7, 1'b0, 1'b0, 1'b1, 8'h07, 4'h7, 2'd1, 1'b1};
      tbl[9]  = '{1'b1, 8'h08, 4'h8, 1'b0, 1'b0, 1'b1, 8'h07, 4'h7, 2'd2, 1'b0};
      tbl[10] = '{1'b1, 8'h09, 4'h9, 1'b0, 1'b1, 1'b0, 8'h00, BUB,  2'd0, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, BUB,  2'd0, 1'b1};
      tbl[12] = '{1'b1, 8'h04, 4'h4, 1'b0, 1'b0, 1'b1, 8'h04, 4'h4, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 8'h05, 4'h5, 1'b1, 1'b1, 1'b0, 8'h00, BUB,  2'd0, 1'b1};

      // reset state
      do_reset();
      chk("reset.valid", {31'd0, valid_out}, 32'd0);
      chk("reset.ready", {31'd0, ready_out}, 32'd1);
      chk("reset.occ", {30'd0, occupancy}, 32'd0);
      chk("reset.ctrl", {28'd0, ctrl_out}, {28'd0, BUB});
      chk("reset.data", {24'd0, data_out}, 32'd0);

      // directed vector table: single word, backpressure ordering, flush
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].vin, tbl[i].d, tbl[i].c, tbl[i].rdy, tbl[i].fl);
         chk($sformatf("vec%0d.valid", i), {31'd0, valid_out}, {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d.ready", i), {31'd0, ready_out}, {31'd0, tbl[i].er});
         chk($sformatf("vec%0d.occ", i), {30'd0, occupancy}, {30'd0, tbl[i].eo});
         chk($sformatf("vec%0d.ctrl", i), {28'd0, ctrl_out}, {28'd0, tbl[i].ec});
         if (tbl[i].ev)
            chk($sformatf("vec%0d.data", i), {24'd0, data_out}, {24'd0, tbl[i].ed});
      end

      // full throughput: 100 back-to-back words
      for (int i = 0; i < 100; i++) begin
         step(1'b1, i[7:0], i[3:0], 1'b1, 1'b0);
         chk($sformatf("thru%0d.data", i), {24'd0, data_out}, i);
         chk($sformatf("thru%0d.valid", i), {31'd0, valid_out}, 32'd1);
         chk($sformatf("thru%0d.ready", i), {31'd0, ready_out}, 32'd1);
         chk($sformatf("thru%0d.occ_le1", i), {31'd0, occupancy <= 2'd1}, 32'd1);
      end
      step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      model_check("thru_drain");

      // async reset while FULL, between clock edges
      step(1'b1, 8'h11, 4'h1, 1'b0, 1'b0);
      step(1'b1, 8'h22, 4'h2, 1'b0, 1'b0);
      model_check("pre_rst_full");
      valid_in = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.valid", {31'd0, valid_out}, 32'd0);
      chk("async_rst.occ", {30'd0, occupancy}, 32'd0);
      chk("async_rst.ready", {31'd0, ready_out}, 32'd1);
      chk("async_rst.ctrl", {28'd0, ctrl_out}, {28'd0, BUB});
      q.delete();
      bub = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h05, 4'h5, 1'b1, 1'b0);
      model_check("post_rst_push");
      chk("post_rst.data", {24'd0, data_out}, 32'h05);

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      // starvation counter: saturation, immune to flush, cleared by rst
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
         chk($sformatf("bub_sat%0d", i), {30'd0, bubble_cnt}, (i < 3) ? i + 1 : 3);
      end
      step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
      chk("bub_flush_sat", {30'd0, bubble_cnt}, 32'd3);
      do_reset();
      chk("bub_rst", {30'd0, bubble_cnt}, 32'd0);
      step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
      chk("bub_flush_keep", {30'd0, bubble_cnt}, 32'd1);
`endif

      // random traffic against the queue model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         logic       v, r, f;
         logic [7:0] d;
         logic [3:0] c;
         v = ($urandom % 4) != 0;
         r = ($urandom % 3) != 0;
         f = ($urandom % 20) == 0;
         d = 8'($urandom);
         c = 4'($urandom);
         step(v, d, c, r, f);
         model_check($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
